sprite_frame_sched: RTL and testbench
=====================================

Name: sprite_frame_sched

Overview:
- Frame-synchronous register scheduler between the Avalon slave bus and the sprite/score overlay datapath of the VGA display.
- Bus writes land in a shadow bank. At the start of vertical blanking the shadow bank is committed to the active bank, so sprite positions never tear mid-frame.
- Also owns the per-frame sequencing the overlay needs: dino run-animation phase and a 4-digit BCD score counter.

Parameters:
- NUM_REGS, 16, number of 8-bit position registers (bus addresses 0..NUM_REGS-1).
- VACTIVE, 480, first vcount value of vertical blanking.
- ANIM_DIV, 8, frames per animation phase step (>=1).
- SCORE_DIV, 6, frames per score increment (>=1).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  bus select
- write  in  1  bus write strobe
- address  in  9  bus word address
- writedata  in  32  bus write data
- vcount  in  10  current line from the VGA timing counters
- active_regs  out  NUM_REGS*8  committed registers; reg i occupies bits [8i+7:8i]
- sprite_state  out  2  animation phase 0,1,2
- score_bcd  out  16  4 BCD digits; [3:0] is the ones digit
- frame_tick  out  1  one-cycle pulse at each frame boundary
- pending  out  1  shadow bank holds uncommitted writes

Behaviour:
- Reset (async, active-high): all shadow and active regs = 0, sprite_state=0, score_bcd=0, run=0, freeze=0, pending=0, frame_tick=0, all divider counters=0, load_pending=0.
- Bus write occurs when chipselect && write. Address map:
  - 0..NUM_REGS-1: shadow[addr] <= writedata[7:0]; sets pending.
  - 16: control. bit0=run (held). bit1=clear (self-clearing strobe). bit2=freeze (held; suppresses commits).
  - 17: score load. Latches writedata[15:0] as load value and sets load_pending. Any nibble >9 is latched as 9.
  - Any other address is ignored.
- Frame boundary: vcount_q is vcount registered one cycle. boundary = (vcount==VACTIVE) && (vcount_q!=VACTIVE). frame_tick is asserted the cycle after boundary, exactly one cycle per frame.
- Commit: on the boundary cycle, if freeze=0, active <= shadow. New values are visible on active_regs the following cycle, i.e. aligned with frame_tick. pending is cleared on commit unless a shadow write occurs in the same cycle.
- Simultaneous shadow write and commit: the commit takes the pre-write shadow contents. The new write stays in shadow, pending stays 1, and it is committed at the next boundary.
- Animation: on frame_tick with run=1, anim_cnt increments. When anim_cnt reaches ANIM_DIV-1 it wraps to 0 and sprite_state advances 0->1->2->0. Value 3 is never produced. With run=0, counters and sprite_state hold.
- Score, on frame_tick, priority order:
  1. load_pending: score <= load value, score_div <= 0, load_pending cleared.
  2. Otherwise if run=1: score_div increments. At SCORE_DIV-1 it wraps and score increments in BCD with per-digit carry; 9999 wraps to 0000.
- Clear strobe: takes effect the cycle after the write. score=0, score_div=0, anim_cnt=0, sprite_state=0, load_pending cleared. Clear overrides any load or increment landing in the same cycle.
- A freeze write does not affect score or animation sequencing.
- Reset mid-frame: all state returns to reset values immediately. The first boundary after reset release commits the (zero) shadow bank.
- Fully synchronous outputs; no combinational path from bus inputs to outputs.

Test Plan:
- Write shadow[0]=0x64 and shadow[1]=0x32 at vcount=100 -> active_regs[7:0] stays 0 and pending=1 until vcount reaches 480. Next cycle active_regs[7:0]=0x64, [15:8]=0x32, frame_tick=1 for one cycle, pending=0.
- Write shadow[2]=0xAA in the exact boundary cycle -> that commit leaves reg2 at its old value and pending=1. reg2=0xAA after the next frame boundary.
- Set control=0x1 and run 48 frames with defaults -> sprite_state sequence 0,1,2,0,1,2 (one step per 8 frames), score_bcd=0x0008.
- Load 0x9998, run, 12 frames -> score 0x9999 then 0x0000 (wrap). Load 0x12F4 -> score_bcd=0x1294 at the next frame_tick.
- Write control=0x3 (run+clear) in the same cycle a load is pending and a boundary occurs -> score_bcd=0, sprite_state=0, load discarded.
- Set freeze=1, write reg0=0x10, pass 2 boundaries -> active reg0 unchanged and pending=1. Clear freeze -> 0x10 committed at the next boundary. Assert reset mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sprite_frame_sched.sv
// Frame-synchronous register scheduler for the VGA sprite/score overlay.
// Bus writes land in a shadow bank that is committed to the active bank at the start of vertical blanking.
module sprite_frame_sched #(
  parameter int NUM_REGS  = 16,
  parameter int VACTIVE   = 480,
  parameter int ANIM_DIV  = 8,
  parameter int SCORE_DIV = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [8:0]            address,
  input  logic [31:0]           writedata,
  input  logic [9:0]            vcount,
  output logic [NUM_REGS*8-1:0] active_regs,
  output logic [1:0]            sprite_state,
  output logic [15:0]           score_bcd,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int AW = $clog2(ANIM_DIV + 1);
  localparam int SW = $clog2(SCORE_DIV + 1);
  localparam logic [8:0] CTRL_ADDR = 9'd16;
  localparam logic [8:0] LOAD_ADDR = 9'd17;

  logic [NUM_REGS-1:0][7:0] shadow;
  logic [NUM_REGS-1:0][7:0] active;
  logic [9:0]               vcount_q;
  logic                     run;
  logic                     freeze;
  logic                     clear_q;
  logic [15:0]              load_val;
  logic                     load_pending;
  logic [AW-1:0]            anim_cnt;
  logic [SW-1:0]            score_div;

  logic bus_wr;
  logic reg_wr;
  logic ctrl_wr;
  logic load_wr;
  logic boundary;
  logic commit;
  logic unused_bits;

  assign bus_wr   = chipselect && write;
  assign reg_wr   = bus_wr && (address < 9'(NUM_REGS));
  assign ctrl_wr  = bus_wr && (address == CTRL_ADDR);
  assign load_wr  = bus_wr && (address == LOAD_ADDR);
  assign boundary = (vcount == 10'(VACTIVE)) && (vcount_q != 10'(VACTIVE));
  assign commit   = boundary && !freeze;

  assign active_regs = active;
  assign unused_bits = ^writedata[31:16];

  // Any nibble outside 0..9 is clamped so the score register always holds valid BCD.
  function automatic logic [15:0] bcd_sat(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Bus capture, frame boundary detection and shadow-to-active commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: both banks are flop-based and must read zero after reset, so they are reset like any other register.
      shadow     <= '0;
      active     <= '0;
      vcount_q   <= '0;
      frame_tick <= 1'b0;
      pending    <= 1'b0;
      run        <= 1'b0;
      freeze     <= 1'b0;
      clear_q    <= 1'b0;
      load_val   <= '0;
    end else begin
      // NOTE: non-blocking assignments make the commit read the pre-write shadow when both happen in one cycle.
      vcount_q   <= vcount;
      frame_tick <= boundary;
      clear_q    <= ctrl_wr && writedata[1];
      if (ctrl_wr) begin
        run    <= writedata[0];
        freeze <= writedata[2];
      end
      if (reg_wr)  shadow[address[IW-1:0]] <= writedata[7:0];
      if (commit)  active <= shadow;
      if (reg_wr)      pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      if (load_wr) load_val <= bcd_sat(writedata[15:0]);
    end
  end

  // Per-frame animation phase and score sequencing; clear beats everything landing in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprite_state <= 2'd0;
      score_bcd    <= '0;
      anim_cnt     <= '0;
      score_div    <= '0;
      load_pending <= 1'b0;
    end else if (clear_q) begin
      sprite_state <= 2'd0;
      score_bcd    <= '0;
      anim_cnt     <= '0;
      score_div    <= '0;
      load_pending <= 1'b0;
    end else begin
      if (frame_tick && load_pending) begin
        score_bcd    <= load_val;
        score_div    <= '0;
        load_pending <= 1'b0;
      end else if (frame_tick && run) begin
        if (score_div == SW'(SCORE_DIV - 1)) begin
          score_div <= '0;
          score_bcd <= bcd_inc(score_bcd);
        end else begin
          score_div <= score_div + 1'b1;
        end
      end
      // A new load arriving with the tick re-arms for the following frame.
      if (load_wr) load_pending <= 1'b1;

      if (frame_tick && run) begin
        if (anim_cnt == AW'(ANIM_DIV - 1)) begin
          anim_cnt     <= '0;
          sprite_state <= (sprite_state == 2'd2) ? 2'd0 : sprite_state + 2'd1;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_frame_sched.sv
// Self-checking bench for sprite_frame_sched: a transaction-level model pushes expected frame results
// into a scoreboard queue, and each frame's DUT output is popped and compared when frame_tick appears.
module tb_sprite_frame_sched;

  localparam int NUM_REGS  = 16;
  localparam int VACTIVE   = 480;
  localparam int ANIM_DIV  = 8;
  localparam int SCORE_DIV = 6;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  chipselect;
  logic                  write;
  logic [8:0]            address;
  logic [31:0]           writedata;
  logic [9:0]            vcount;
  logic [NUM_REGS*8-1:0] active_regs;
  logic [1:0]            sprite_state;
  logic [15:0]           score_bcd;
  logic                  frame_tick;
  logic                  pending;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [NUM_REGS*8-1:0] active;
    logic                  pending;
    logic [1:0]            state;
    logic [15:0]           score;
  } exp_t;

  exp_t sb[$];

  // Reference model, kept at transaction level with a decimal score.
  logic [NUM_REGS-1:0][7:0] m_shadow;
  logic [NUM_REGS-1:0][7:0] m_active;
  bit m_run, m_freeze, m_pending, m_load_pend;
  int m_anim, m_state, m_div, m_score, m_load;

  sprite_frame_sched #(
    .NUM_REGS (NUM_REGS),
    .VACTIVE  (VACTIVE),
    .ANIM_DIV (ANIM_DIV),
    .SCORE_DIV(SCORE_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .vcount      (vcount),
    .active_regs (active_regs),
    .sprite_state(sprite_state),
    .score_bcd   (score_bcd),
    .frame_tick  (frame_tick),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int sat_load(input logic [15:0] d);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      int dig;
      dig = int'(d[4*i +: 4]);
      if (dig > 9) dig = 9;
      r = r * 10 + dig;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic m_reset();
    m_shadow = '0; m_active = '0;
    m_run = 0; m_freeze = 0; m_pending = 0; m_load_pend = 0;
    m_anim = 0; m_state = 0; m_div = 0; m_score = 0; m_load = 0;
  endtask

  task automatic m_clear();
    m_anim = 0; m_state = 0; m_div = 0; m_score = 0; m_load_pend = 0;
  endtask

  task automatic m_write(input int a, input logic [31:0] d, output bit clr);
    clr = 0;
    if (a < NUM_REGS) begin
      m_shadow[a] = d[7:0];
      m_pending   = 1;
    end else if (a == 16) begin
      m_run    = d[0];
      m_freeze = d[2];
      clr      = d[1];
    end else if (a == 17) begin
      m_load      = sat_load(d[15:0]);
      m_load_pend = 1;
    end
  endtask

  task automatic m_tick();
    if (m_load_pend) begin
      m_score = m_load; m_div = 0; m_load_pend = 0;
    end else if (m_run) begin
      m_div++;
      if (m_div == SCORE_DIV) begin
        m_div = 0;
        m_score = (m_score + 1) % 10000;
      end
    end
    if (m_run) begin
      m_anim++;
      if (m_anim == ANIM_DIV) begin
        m_anim = 0;
        m_state = (m_state + 1) % 3;
      end
    end
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    bit clr;
    @(posedge clk); #1;
    chipselect = 1; write = 1; address = 9'(a); writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
    m_write(a, d, clr);
    if (clr) m_clear();
  endtask

  // One frame boundary; optionally a bus write lands in the exact boundary cycle.
  task automatic do_frame(input bit wr, input int a, input logic [31:0] d);
    exp_t e;
    bit   clr;
    bit   found;
    @(posedge clk); #1;
    vcount = 10'(VACTIVE - 1);
    @(posedge clk); #1;
    vcount = 10'(VACTIVE);
    if (wr) begin
      chipselect = 1; write = 1; address = 9'(a); writedata = d;
    end
    clr = 0;
    if (!m_freeze) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    if (wr) m_write(a, d, clr);
    m_tick();
    if (clr) m_clear();
    e.active = m_active; e.pending = m_pending;
    e.state = 2'(m_state); e.score = to_bcd(m_score);
    sb.push_back(e);
    @(posedge clk); #1;
    chipselect = 0; write = 0;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1;
        break;
      end
    end
    e = sb.pop_front();
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL frame_tick_timeout: frame_tick=%0b, required 1 within 4 cycles", frame_tick);
    end else begin
      tests_run++;
      if (active_regs !== e.active) begin
        tests_failed++;
        $display("FAIL active_regs: got %h, required %h", active_regs, e.active);
      end
      tests_run++;
      if (pending !== e.pending) begin
        tests_failed++;
        $display("FAIL pending_after_commit: got %0b, required %0b", pending, e.pending);
      end
      @(negedge clk);
      tests_run++;
      if (frame_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL frame_tick_width: got %0b, required 0 on second cycle", frame_tick);
      end
      tests_run++;
      if (sprite_state !== e.state) begin
        tests_failed++;
        $display("FAIL sprite_state: got %0d, required %0d", sprite_state, e.state);
      end
      tests_run++;
      if (score_bcd !== e.score) begin
        tests_failed++;
        $display("FAIL score_bcd: got %h, required %h", score_bcd, e.score);
      end
    end
    @(posedge clk); #1;
    vcount = 10'd100;
  endtask

  task automatic check_outputs_zero(input string tag);
    tests_run++;
    if ({active_regs, sprite_state, score_bcd, frame_tick, pending} !== '0) begin
      tests_failed++;
      $display("FAIL %s: active=%h state=%0d score=%h tick=%0b pending=%0b, required all 0",
               tag, active_regs, sprite_state, score_bcd, frame_tick, pending);
    end
  endtask

  task automatic check_score(input string tag, input logic [15:0] req);
    tests_run++;
    if (score_bcd !== req) begin
      tests_failed++;
      $display("FAIL %s: score got %h, required %h", tag, score_bcd, req);
    end
  endtask

  task automatic test_reset();
    reset = 1; chipselect = 0; write = 0; address = '0; writedata = '0; vcount = 10'd0;
    m_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    #2 reset = 0;
  endtask

  task automatic test_commit();
    vcount = 10'd100;
    bus_write(0, 32'h0000_0064);
    bus_write(1, 32'h0000_0032);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (active_regs[15:0] !== 16'h0000 || pending !== 1'b1) begin
        tests_failed++;
        $display("FAIL precommit_hold: active[15:0]=%h pending=%0b, required 0000 and 1",
                 active_regs[15:0], pending);
      end
    end
    do_frame(0, 0, 0);
    tests_run++;
    if (active_regs[15:0] !== 16'h3264) begin
      tests_failed++;
      $display("FAIL commit_value: active[15:0]=%h, required 3264", active_regs[15:0]);
    end
    bus_write(18, 32'h0000_00FF);
    bus_write(511, 32'h0000_00FF);
    @(negedge clk);
    tests_run++;
    if (pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_address: pending=%0b, required 0", pending);
    end
  endtask

  task automatic test_boundary_write();
    do_frame(1, 2, 32'h0000_00AA);
    do_frame(0, 0, 0);
    tests_run++;
    if (active_regs[23:16] !== 8'hAA) begin
      tests_failed++;
      $display("FAIL boundary_write_late: reg2=%h, required aa", active_regs[23:16]);
    end
  endtask

  task automatic test_animation();
    bus_write(16, 32'h1);
    for (int f = 0; f < 48; f++) do_frame(0, 0, 0);
    check_score("anim_48_score", 16'h0008);
    tests_run++;
    if (sprite_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL anim_48_state: got %0d, required 0", sprite_state);
    end
  endtask

  task automatic test_score_load();
    bus_write(17, 32'h0000_9998);
    for (int f = 0; f < 7; f++) do_frame(0, 0, 0);
    check_score("score_9999", 16'h9999);
    for (int f = 0; f < 6; f++) do_frame(0, 0, 0);
    check_score("score_wrap", 16'h0000);
    bus_write(17, 32'h0000_12F4);
    do_frame(0, 0, 0);
    check_score("load_saturate", 16'h1294);
  endtask

  task automatic test_clear_override();
    bus_write(17, 32'h0000_0555);
    do_frame(1, 16, 32'h3);
    check_score("clear_beats_load", 16'h0000);
    do_frame(0, 0, 0);
    check_score("load_discarded", 16'h0000);
  endtask

  task automatic test_freeze();
    bus_write(16, 32'h4);
    bus_write(0, 32'h0000_0010);
    do_frame(0, 0, 0);
    do_frame(0, 0, 0);
    tests_run++;
    if (active_regs[7:0] !== 8'h64 || pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL freeze_hold: reg0=%h pending=%0b, required 64 and 1", active_regs[7:0], pending);
    end
    bus_write(16, 32'h0);
    do_frame(0, 0, 0);
    tests_run++;
    if (active_regs[7:0] !== 8'h10) begin
      tests_failed++;
      $display("FAIL freeze_release: reg0=%h, required 10", active_regs[7:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus_write(3, 32'h0000_0077);
    bus_write(16, 32'h1);
    @(posedge clk); #3;
    reset = 1;
    #1;
    check_outputs_zero("async_reset");
    m_reset();
    @(negedge clk); #2;
    reset = 0;
    do_frame(0, 0, 0);
    check_outputs_zero("post_reset_frame_idle");
  endtask

  initial begin
    test_reset();
    test_commit();
    test_boundary_write();
    test_animation();
    test_score_load();
    test_clear_override();
    test_freeze();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
